// File: rtl/layer6_argmax.sv
// Final ECG classification stage: snapshots the layer-6 ReLU outputs and scans
// them one per cycle for the largest float32 value, reporting its index.
`timescale 1ns/1ps
module layer6_argmax #(
  parameter int N_NODES = 5,
  parameter int IDX_W   = $clog2(N_NODES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_NODES*32-1:0]  node_bus,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       max_idx,
  output logic [31:0]            max_val,
  output logic                   nan_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        snap_q [N_NODES];
  logic [IDX_W-1:0]   cnt_q;
  logic [31:0]        best_val_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic               nan_acc_q;
  logic               busy_q, done_q, nan_flag_q;
  logic [IDX_W-1:0]   max_idx_q;
  logic [31:0]        max_val_q;

  logic [31:0]        word_cur;
  logic               word_nan;
  logic [31:0]        word_eff;
  logic               better;
  logic               last_scan;
  logic [31:0]        cand_val;
  logic [IDX_W-1:0]   cand_idx;
  logic               cand_nan;

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  // Negative values cannot legally leave a ReLU; clamp them (and -0.0) to +0.0.
  function automatic logic [31:0] relu_clip(input logic [31:0] w);
    return w[31] ? 32'h0 : w;
  endfunction

  function automatic logic gt_nonneg(input logic [31:0] a, input logic [31:0] b);
    return a[30:0] > b[30:0];
  endfunction

  // Candidate best after evaluating the current snapshot word.
  always_comb begin
    word_cur  = snap_q[cnt_q];
    word_nan  = is_nan(word_cur);
    word_eff  = relu_clip(word_cur);
    better    = !word_nan && gt_nonneg(word_eff, best_val_q);
    last_scan = (cnt_q == IDX_W'(N_NODES - 1));
    cand_val  = better ? word_eff : best_val_q;
    cand_idx  = better ? cnt_q : best_idx_q;
    cand_nan  = nan_acc_q | word_nan;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last_scan) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == SCAN) && last_scan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NODES; k++) snap_q[k] <= 32'h0;
      cnt_q      <= '0;
      best_val_q <= 32'h0;
      best_idx_q <= '0;
      nan_acc_q  <= 1'b0;
      max_idx_q  <= '0;
      max_val_q  <= 32'h0;
      nan_flag_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N_NODES; k++) snap_q[k] <= node_bus[32*k +: 32];
            cnt_q      <= '0;
            best_val_q <= 32'h0;
            best_idx_q <= '0;
            nan_acc_q  <= 1'b0;
          end
        end
        SCAN: begin
          cnt_q      <= cnt_q + IDX_W'(1);
          best_val_q <= cand_val;
          best_idx_q <= cand_idx;
          nan_acc_q  <= cand_nan;
          if (last_scan) begin
            max_idx_q  <= cand_idx;
            max_val_q  <= cand_val;
            nan_flag_q <= cand_nan;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign max_idx  = max_idx_q;
  assign max_val  = max_val_q;
  assign nan_flag = nan_flag_q;

endmodule

// File: tb/tb_layer6_argmax.sv
// Directed bench for layer6_argmax: one task per scenario with inline checks.
`timescale 1ns/1ps
module tb_layer6_argmax;

  localparam int N = 5;
  localparam int IW = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [N*32-1:0] node_bus;
  logic            busy, done, nan_flag;
  logic [IW-1:0]   max_idx;
  logic [31:0]     max_val;

  int n_cmp = 0;
  int n_bad = 0;

  layer6_argmax #(.N_NODES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .node_bus(node_bus),
    .busy(busy), .done(done), .max_idx(max_idx), .max_val(max_val),
    .nan_flag(nan_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*32-1:0] pack5(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] a2, input logic [31:0] a3,
                                            input logic [31:0] a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  // Drives one scan; returns edges from sampling edge to done (-1 if none).
  task automatic run_scan(input logic [N*32-1:0] bus, output int lat);
    @(posedge clk); #1;
    node_bus = bus;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin lat = i - 1; break; end
      @(posedge clk); #1;
    end
    if (done && lat < 0) lat = 20;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; node_bus = '0;
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (max_idx !== '0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", max_idx); end
    n_cmp++; if (max_val !== 32'h0) begin n_bad++; $display("FAIL reset_val got %h want 0", max_val); end
    n_cmp++; if (nan_flag !== 1'b0) begin n_bad++; $display("FAIL reset_nan got %b want 0", nan_flag); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_scan(pack5(32'h3F800000, 32'h40600000, 32'h3E800000, 32'h40000000, 32'h0), lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL basic_latency got %0d want 5", lat); end
    n_cmp++; if (max_idx !== 3'd1) begin n_bad++; $display("FAIL basic_idx got %0d want 1", max_idx); end
    n_cmp++; if (max_val !== 32'h40600000) begin n_bad++; $display("FAIL basic_val got %h want 40600000", max_val); end
    n_cmp++; if (nan_flag !== 1'b0) begin n_bad++; $display("FAIL basic_nan got %b want 0", nan_flag); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_done got %b want 1", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_idle got %b want 0", busy); end
    n_cmp++; if (max_idx !== 3'd1) begin n_bad++; $display("FAIL basic_hold_idx got %0d want 1", max_idx); end
  endtask

  task automatic test_ties();
    int lat;
    run_scan(pack5(32'h0, 32'h0, 32'h40000000, 32'h0, 32'h40000000), lat);
    n_cmp++; if (max_idx !== 3'd2) begin n_bad++; $display("FAIL tie_idx got %0d want 2", max_idx); end
    n_cmp++; if (max_val !== 32'h40000000) begin n_bad++; $display("FAIL tie_val got %h want 40000000", max_val); end
    run_scan(pack5(32'h0, 32'h0, 32'h0, 32'h0, 32'h0), lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL zero_latency got %0d want 5", lat); end
    n_cmp++; if (max_idx !== 3'd0) begin n_bad++; $display("FAIL zero_idx got %0d want 0", max_idx); end
    n_cmp++; if (max_val !== 32'h0) begin n_bad++; $display("FAIL zero_val got %h want 0", max_val); end
  endtask

  task automatic test_nan();
    int lat;
    run_scan(pack5(32'h0, 32'h3F800000, 32'h0, 32'h7FC00000, 32'h0), lat);
    n_cmp++; if (max_idx !== 3'd1) begin n_bad++; $display("FAIL nan_idx got %0d want 1", max_idx); end
    n_cmp++; if (max_val !== 32'h3F800000) begin n_bad++; $display("FAIL nan_val got %h want 3f800000", max_val); end
    n_cmp++; if (nan_flag !== 1'b1) begin n_bad++; $display("FAIL nan_flag got %b want 1", nan_flag); end
    run_scan(pack5(32'h3E800000, 32'h0, 32'h0, 32'h0, 32'h0), lat);
    n_cmp++; if (nan_flag !== 1'b0) begin n_bad++; $display("FAIL nan_clear got %b want 0", nan_flag); end
    n_cmp++; if (max_val !== 32'h3E800000) begin n_bad++; $display("FAIL clean_val got %h want 3e800000", max_val); end
  endtask

  task automatic test_inf_neg();
    int lat;
    run_scan(pack5(32'h3F800000, 32'h40600000, 32'h0, 32'h0, 32'h7F800000), lat);
    n_cmp++; if (max_idx !== 3'd4) begin n_bad++; $display("FAIL inf_idx got %0d want 4", max_idx); end
    n_cmp++; if (max_val !== 32'h7F800000) begin n_bad++; $display("FAIL inf_val got %h want 7f800000", max_val); end
    run_scan(pack5(32'hBF800000, 32'h0, 32'h0, 32'h0, 32'h0), lat);
    n_cmp++; if (max_idx !== 3'd0) begin n_bad++; $display("FAIL neg_idx got %0d want 0", max_idx); end
    n_cmp++; if (max_val !== 32'h0) begin n_bad++; $display("FAIL neg_val got %h want 0", max_val); end
  endtask

  task automatic test_back_to_back();
    int pulses, first;
    logic [IW-1:0] idx_at_done;
    logic [31:0]   val_at_done;
    pulses = 0; first = -1; idx_at_done = '0; val_at_done = '0;
    @(posedge clk); #1;
    node_bus = pack5(32'h3F800000, 32'h40600000, 32'h3E800000, 32'h40000000, 32'h0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    node_bus = pack5(32'h0, 32'h0, 32'h0, 32'h0, 32'h7F800000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 2; i < 14; i++) begin
      if (done) begin
        pulses++;
        if (first < 0) begin first = i; idx_at_done = max_idx; val_at_done = max_val; end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    n_cmp++; if (first !== 5) begin n_bad++; $display("FAIL b2b_latency got %0d want 5", first); end
    n_cmp++; if (idx_at_done !== 3'd1) begin n_bad++; $display("FAIL b2b_idx got %0d want 1", idx_at_done); end
    n_cmp++; if (val_at_done !== 32'h40600000) begin n_bad++; $display("FAIL b2b_val got %h want 40600000", val_at_done); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, pulses;
    pulses = 0;
    @(posedge clk); #1;
    node_bus = pack5(32'h0, 32'h0, 32'h40000000, 32'h0, 32'h0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_cmp++; if (max_idx !== '0) begin n_bad++; $display("FAIL rst_mid_idx got %0d want 0", max_idx); end
    n_cmp++; if (max_val !== 32'h0) begin n_bad++; $display("FAIL rst_mid_val got %h want 0", max_val); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_nodone got %0d want 0", pulses); end
    run_scan(pack5(32'h0, 32'h0, 32'h0, 32'h40000000, 32'h3F800000), lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL rst_after_latency got %0d want 5", lat); end
    n_cmp++; if (max_idx !== 3'd3) begin n_bad++; $display("FAIL rst_after_idx got %0d want 3", max_idx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_nan();
    test_inf_neg();
    test_back_to_back();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
